hazard_control_unit: RTL
========================

# hazard_control_unit

Pipeline hazard controller that drives the stall and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers from the control bits those registers carry downstream. It resolves four cases. Load-use data hazards and condition-flag hazards insert ID/EX bubbles. Taken branches flush IF/ID. Data-memory wait states freeze the pipeline, with a timeout that raises a sticky fault. It also produces operand forwarding selects and saturating stall/flush performance counters.

## Interface
- CNT_W, 16, width of performance counters
- TIMEOUT, 255, max consecutive memory-wait cycles before fault (1..255)
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous, active-high reset
- Rn_ID, Rm_ID, Rd_ID  in  4 each  source register numbers of instruction in ID
- UseRn_ID, UseRm_ID, UseRd_ID  in  1 each  source actually read (Rd for stores)
- CondBr_ID  in  1  ID holds a conditional (cond != AL) instruction
- Branch_Taken  in  1  ID resolved a taken branch
- Rd_EX, Rd_MEM, Rd_WB  in  4 each  destination register per stage
- rf_EX, rf_MEM, rf_WB  in  1 each  register-file write enable per stage
- Load_EX, S_EX  in  1 each  EX is a load / EX updates flags
- Enable_MEM  in  1  MEM stage accessing data memory
- Mem_Ready  in  1  data memory completes access this cycle
- Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM  out  1 each  hold register
- Clear_IFID, Clear_IDEX, Clear_MEMWB  out  1 each  load bubble next edge
- Fwd_Rn, Fwd_Rm, Fwd_Rd  out  2 each  00 regfile, 01 EX, 10 MEM, 11 WB
- Mem_Fault  out  1  sticky memory-timeout flag
- Stall_Cnt, Flush_Cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states RUN, HOLD, FAULT; hold timer 8 bits.
- RUN: Enable_MEM & !Mem_Ready -> freeze this cycle, next HOLD, timer=1.
- HOLD: !Mem_Ready -> freeze, timer+1; timer reaching TIMEOUT -> FAULT, Mem_Fault=1. Mem_Ready -> no freeze this cycle, next RUN, timer=0.
- FAULT: freeze permanently; only CLR exits.
- Freeze: all four Stall_* =1, Clear_MEMWB=1, Clear_IFID=Clear_IDEX=0.
- Load-use: Load_EX & rf_EX & Rd_EX matches any used ID source -> Stall_PC=Stall_IFID=1, Clear_IDEX=1.
- Flag hazard: CondBr_ID & S_EX -> same outputs as load-use.
- Branch flush: Branch_Taken with no freeze/stall -> Clear_IFID=1. Ignored while stalled; branch re-evaluated later.
- Priority: freeze > load-use > flag hazard > branch flush. Inactive outputs are 0.
- Forwarding per source: match requires Use_x, rf_stage, Rd_stage==source, and Rd_stage != 4'hF (PC never forwarded).
- Forwarding priority EX (not when Load_EX) > MEM > WB > 00.
- Stall_Cnt +1 each cycle Stall_PC=1; Flush_Cnt +1 each cycle Clear_IFID=1. Both saturate at all-ones.

## Timing
- Stall/clear/forward outputs are combinational from inputs and current state; same-cycle response, acted on by pipeline registers at the next CLK edge.
- State, timer, Mem_Fault and counters update on the rising CLK edge.
- Reset (async, any time, including mid-HOLD): state RUN, timer 0, Mem_Fault 0, counters 0.
- While CLR=1: Stall_* =0, Clear_* =1, Fwd_* =00.
- Load-use and flag stalls last exactly 1 cycle. The bubble in EX clears Load_EX/S_EX, and MEM forwarding then covers the load.
- Mem wait of N cycles (N<TIMEOUT) gives N freeze cycles, then resume. Mem_Fault rises the edge after the TIMEOUT-th consecutive wait cycle.

## Test plan
- Load-use: LDR R2 in EX (Load_EX=1, rf_EX=1, Rd_EX=2), ID uses Rn=2 -> one cycle Stall_PC=Stall_IFID=Clear_IDEX=1. Next cycle, Rd_MEM=2 -> Fwd_Rn=10, no stall. Stall_Cnt=1.
- Forward priority: Rd_EX=Rd_MEM=Rd_WB=3, all rf=1, Load_EX=0, Rm_ID=3 used -> Fwd_Rm=01. Same with Rd=15 -> Fwd_Rm=00.
- Flag hazard plus branch: CondBr_ID=1, S_EX=1, Branch_Taken=1 -> stall, Clear_IFID=0. Next cycle S_EX=0 -> Clear_IFID=1, Flush_Cnt=1.
- Memory wait: Enable_MEM=1, Mem_Ready low 3 cycles -> 3 cycles all Stall_* =1 and Clear_MEMWB=1. Mem_Ready=1 -> freeze drops, state RUN.
- Timeout: TIMEOUT=4, Mem_Ready held 0 -> Mem_Fault=1 after 4th wait edge and stays 1 with Mem_Ready=1. CLR pulse mid-FAULT -> Mem_Fault=0, counters 0.
- Saturation: CNT_W=4, 20 stall cycles -> Stall_Cnt holds 15.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-unit bundle: per-stage register/control bits in, stall/clear/forward controls out.
interface hazard_control_unit_if #(parameter int CNT_W = 16);
  logic [3:0]       Rn_ID, Rm_ID, Rd_ID;
  logic             UseRn_ID, UseRm_ID, UseRd_ID;
  logic             CondBr_ID, Branch_Taken;
  logic [3:0]       Rd_EX, Rd_MEM, Rd_WB;
  logic             rf_EX, rf_MEM, rf_WB;
  logic             Load_EX, S_EX;
  logic             Enable_MEM, Mem_Ready;
  logic             Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM;
  logic             Clear_IFID, Clear_IDEX, Clear_MEMWB;
  logic [1:0]       Fwd_Rn, Fwd_Rm, Fwd_Rd;
  logic             Mem_Fault;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

  modport master (
    output Rn_ID, Rm_ID, Rd_ID, UseRn_ID, UseRm_ID, UseRd_ID, CondBr_ID, Branch_Taken,
           Rd_EX, Rd_MEM, Rd_WB, rf_EX, rf_MEM, rf_WB, Load_EX, S_EX, Enable_MEM, Mem_Ready,
    input  Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM, Clear_IFID, Clear_IDEX, Clear_MEMWB,
           Fwd_Rn, Fwd_Rm, Fwd_Rd, Mem_Fault, Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  Rn_ID, Rm_ID, Rd_ID, UseRn_ID, UseRm_ID, UseRd_ID, CondBr_ID, Branch_Taken,
           Rd_EX, Rd_MEM, Rd_WB, rf_EX, rf_MEM, rf_WB, Load_EX, S_EX, Enable_MEM, Mem_Ready,
    output Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM, Clear_IFID, Clear_IDEX, Clear_MEMWB,
           Fwd_Rn, Fwd_Rm, Fwd_Rd, Mem_Fault, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller: memory-wait freeze FSM with sticky timeout fault, load-use/flag bubbles,
// branch flush, operand forwarding selects and saturating stall/flush counters.
module hazard_control_unit #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic                CLK,
  input logic                CLR,
  hazard_control_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

  state_t           state;
  logic [7:0]       timer;
  logic [8:0]       timer_nxt;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic wait_cyc, freeze, load_use, flag_haz, bubble, flush;
  logic ex_ok, mem_ok, wb_ok;

  function automatic logic [1:0] fwd_sel(
    input logic u, input logic [3:0] s,
    input logic e_ok, input logic [3:0] e_rd,
    input logic m_ok, input logic [3:0] m_rd,
    input logic w_ok, input logic [3:0] w_rd
  );
    if (u && e_ok && e_rd == s)      return 2'b01;
    else if (u && m_ok && m_rd == s) return 2'b10;
    else if (u && w_ok && w_rd == s) return 2'b11;
    else                             return 2'b00;
  endfunction

  always_comb begin
    wait_cyc = !bus.Mem_Ready && (state == HOLD || (state == RUN && bus.Enable_MEM));
    freeze   = (state == FAULT) || wait_cyc;
    load_use = bus.Load_EX && bus.rf_EX &&
               ((bus.UseRn_ID && bus.Rn_ID == bus.Rd_EX) ||
                (bus.UseRm_ID && bus.Rm_ID == bus.Rd_EX) ||
                (bus.UseRd_ID && bus.Rd_ID == bus.Rd_EX));
    flag_haz = bus.CondBr_ID && bus.S_EX;
    bubble   = !freeze && (load_use || flag_haz);
    // A taken branch seen during a stall is dropped; ID re-resolves it once the stall clears.
    flush    = !freeze && !bubble && bus.Branch_Taken;
    // A loaded value is not available in EX, so a load in EX never forwards; r15 is the PC.
    ex_ok    = bus.rf_EX && !bus.Load_EX && bus.Rd_EX != 4'hF;
    mem_ok   = bus.rf_MEM && bus.Rd_MEM != 4'hF;
    wb_ok    = bus.rf_WB && bus.Rd_WB != 4'hF;
  end

  always_comb begin
    bus.Stall_PC    = !CLR && (freeze || bubble);
    bus.Stall_IFID  = !CLR && (freeze || bubble);
    bus.Stall_IDEX  = !CLR && freeze;
    bus.Stall_EXMEM = !CLR && freeze;
    bus.Clear_IFID  = CLR || flush;
    bus.Clear_IDEX  = CLR || bubble;
    bus.Clear_MEMWB = CLR || freeze;
    bus.Fwd_Rn = CLR ? 2'b00 : fwd_sel(bus.UseRn_ID, bus.Rn_ID, ex_ok, bus.Rd_EX,
                                       mem_ok, bus.Rd_MEM, wb_ok, bus.Rd_WB);
    bus.Fwd_Rm = CLR ? 2'b00 : fwd_sel(bus.UseRm_ID, bus.Rm_ID, ex_ok, bus.Rd_EX,
                                       mem_ok, bus.Rd_MEM, wb_ok, bus.Rd_WB);
    bus.Fwd_Rd = CLR ? 2'b00 : fwd_sel(bus.UseRd_ID, bus.Rd_ID, ex_ok, bus.Rd_EX,
                                       mem_ok, bus.Rd_MEM, wb_ok, bus.Rd_WB);
  end

  assign timer_nxt     = {1'b0, timer} + 9'd1;
  assign bus.Mem_Fault = mem_fault;
  assign bus.Stall_Cnt = stall_cnt;
  assign bus.Flush_Cnt = flush_cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= RUN;
      timer     <= 8'd0;
      mem_fault <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.Enable_MEM && !bus.Mem_Ready) begin
            timer <= 8'd1;
            if (TIMEOUT <= 1) begin
              state     <= FAULT;
              mem_fault <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.Mem_Ready) begin
            state <= RUN;
            timer <= 8'd0;
          end else begin
            timer <= timer_nxt[7:0];
            if (timer_nxt >= 9'(TIMEOUT)) begin
              state     <= FAULT;
              mem_fault <= 1'b1;
            end
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
      if (bus.Stall_PC && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.Clear_IFID && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
